// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Execute-stage multiply/divide controller. Owns the architectural HI/LO
//   registers, runs MULT/MULTU on an internal two-stage 33x33 multiplier and
//   drives an external iterative divider through a div_op / div_done handshake.
//   The pipeline is held via `stall` while an operation is in progress.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   ex_valid, ex_op         EX instruction valid and opcode
//                           (001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO)
//   ex_rs, ex_rt            source operands (rs = dividend / multiplicand)
//   ex_flush                cancel the in-flight operation
//   stall                   hold EX and earlier stages
//   hi, lo                  architectural HI/LO
//   div_op                  divider command: 10 signed, 01 unsigned, 00 idle
//   div_dividend/divisor    registered divider operands
//   div_result, div_done    divider {quotient, remainder} and idle/valid flag

module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [2:0]  ex_op,
    input  logic [31:0] ex_rs,
    input  logic [31:0] ex_rt,
    input  logic        ex_flush,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [1:0]  div_op,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [63:0] div_result,
    input  logic        div_done
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [2:0] {
        IDLE,
        MUL1,
        MUL2,
        DIV_ISSUE,
        DIV_WAIT,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic        take;
    logic        is_mul;
    logic        is_div;
    logic [32:0] mul_a;
    logic [32:0] mul_b;
    logic [65:0] product;
    logic        unused_product_bits;

    // Only the low 64 bits of the 33x33 product are architecturally visible.
    assign unused_product_bits = ^product[65:64];

    assign take   = ex_valid && !ex_flush;
    assign is_mul = (ex_op == OP_MULT) || (ex_op == OP_MULTU);
    assign is_div = (ex_op == OP_DIV) || (ex_op == OP_DIVU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and stall. A DIV with a nonzero divisor stays in IDLE while
    // the divider is still finishing a previously flushed operation.
    // Stall is forced low while reset is held so the pipeline is released
    // immediately.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (take && is_mul) begin
                    stall      = 1'b1;
                    state_next = MUL1;
                end else if (take && is_div) begin
                    stall = 1'b1;
                    if (ex_rt == 32'd0) begin
                        state_next = DONE;
                    end else if (div_done) begin
                        state_next = DIV_ISSUE;
                    end
                end
            end
            MUL1: begin
                stall      = 1'b1;
                state_next = ex_flush ? IDLE : MUL2;
            end
            MUL2: begin
                stall      = 1'b1;
                state_next = ex_flush ? IDLE : DONE;
            end
            DIV_ISSUE: begin
                stall      = 1'b1;
                state_next = ex_flush ? IDLE : DIV_WAIT;
            end
            DIV_WAIT: begin
                stall = 1'b1;
                if (ex_flush) begin
                    state_next = IDLE;
                end else if (div_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (!rst_n) begin
            stall = 1'b0;
        end
    end

    // Datapath. div_op defaults to idle every cycle so it is asserted only in
    // the single DIV_ISSUE cycle, which is when the divider samples it. A
    // launched divide that is then flushed keeps running in the divider; its
    // result is simply never written to HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi           <= 32'd0;
            lo           <= 32'd0;
            div_op       <= 2'b00;
            div_dividend <= 32'd0;
            div_divisor  <= 32'd0;
            mul_a        <= 33'd0;
            mul_b        <= 33'd0;
            product      <= 66'd0;
        end else begin
            div_op <= 2'b00;
            case (state)
                IDLE: begin
                    if (take) begin
                        if (ex_op == OP_MTHI) begin
                            hi <= ex_rs;
                        end
                        if (ex_op == OP_MTLO) begin
                            lo <= ex_rs;
                        end
                        if (is_mul) begin
                            mul_a <= {(ex_op == OP_MULT) & ex_rs[31], ex_rs};
                            mul_b <= {(ex_op == OP_MULT) & ex_rt[31], ex_rt};
                        end
                        if (state_next == DIV_ISSUE) begin
                            div_dividend <= ex_rs;
                            div_divisor  <= ex_rt;
                            div_op       <= (ex_op == OP_DIV) ? 2'b10 : 2'b01;
                        end
                    end
                end
                MUL1: begin
                    product <= {{33{mul_a[32]}}, mul_a} * {{33{mul_b[32]}}, mul_b};
                end
                MUL2: begin
                    if (!ex_flush) begin
                        {hi, lo} <= product[63:0];
                    end
                end
                DIV_WAIT: begin
                    if (!ex_flush && div_done) begin
                        lo <= div_result[63:32];
                        hi <= div_result[31:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
module tb_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [2:0]  ex_op;
    logic [31:0] ex_rs;
    logic [31:0] ex_rt;
    logic        ex_flush;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  div_op;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [63:0] div_result;
    logic        div_done;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [31:0] model_hi;
    logic [31:0] model_lo;

    muldiv_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_op        (ex_op),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_flush     (ex_flush),
        .stall        (stall),
        .hi           (hi),
        .lo           (lo),
        .div_op       (div_op),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_result   (div_result),
        .div_done     (div_done)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: full 64-bit product and sign-magnitude divide
    function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint p;
        if (sgn) p = longint'($signed(a)) * longint'($signed(b));
        else     p = longint'({32'd0, a}) * longint'({32'd0, b});
        return p;
    endfunction

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (sgn) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        if (nb == 0) return 64'd0;
        q = na / nb;
        r = na % nb;
        return {q[31:0], r[31:0]};
    endfunction

    // Behavioural iterative divider: samples div_op while idle, drops done
    // for 34 (signed) or 32 (unsigned) cycles, then presents {q, r}
    logic        dv_signed;
    logic [31:0] dv_a;
    logic [31:0] dv_b;
    int          dv_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_done   <= 1'b1;
            div_result <= 64'd0;
            dv_cnt     <= 0;
            dv_signed  <= 1'b0;
            dv_a       <= 32'd0;
            dv_b       <= 32'd0;
        end else if (div_done && div_op != 2'b00) begin
            div_done  <= 1'b0;
            dv_cnt    <= (div_op == 2'b10) ? 34 : 32;
            dv_signed <= (div_op == 2'b10);
            dv_a      <= div_dividend;
            dv_b      <= div_divisor;
        end else if (!div_done) begin
            if (dv_cnt == 1) begin
                div_done   <= 1'b1;
                div_result <= ref_div(dv_signed, dv_a, dv_b);
            end else begin
                dv_cnt <= dv_cnt - 1;
            end
        end
    end

    // Holds the already-driven instruction in EX until stall drops, counting
    // stall cycles and div_op activity, then retires it at the next edge
    task automatic wait_release(output int stall_cycles, output int op_cycles, output logic [1:0] op_seen);
        stall_cycles = 0;
        op_cycles    = 0;
        op_seen      = 2'b00;
        #1;
        while (stall === 1'b1 && stall_cycles <= 300) begin
            if (div_op !== 2'b00) begin
                op_cycles++;
                op_seen = div_op;
            end
            stall_cycles++;
            @(negedge clk);
            #1;
        end
        if (div_op !== 2'b00) begin
            op_cycles++;
            op_seen = div_op;
        end
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        ex_op    = 3'b000;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output int stall_cycles, output int op_cycles, output logic [1:0] op_seen);
        @(negedge clk);
        ex_valid = 1'b1;
        ex_op    = op;
        ex_rs    = rs;
        ex_rt    = rt;
        wait_release(stall_cycles, op_cycles, op_seen);
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        ex_valid = 1'b1;
        ex_op    = OP_MULT;
        ex_rs    = 32'h1;
        ex_rt    = 32'h1;
        ex_flush = 1'b0;
        #1;
        checks_total++; if (stall !== 1'b0) $display("[TB] FAIL reset_stall: got %b expected 0", stall); else checks_passed++;
        checks_total++; if (hi !== 32'd0) $display("[TB] FAIL reset_hi: got %h expected 0", hi); else checks_passed++;
        checks_total++; if (lo !== 32'd0) $display("[TB] FAIL reset_lo: got %h expected 0", lo); else checks_passed++;
        checks_total++; if (div_op !== 2'b00) $display("[TB] FAIL reset_div_op: got %b expected 00", div_op); else checks_passed++;
        checks_total++; if ({div_dividend, div_divisor} !== 64'd0) $display("[TB] FAIL reset_div_operands: got %h expected 0", {div_dividend, div_divisor}); else checks_passed++;
        repeat (2) @(negedge clk);
        ex_valid = 1'b0;
        ex_op    = 3'b000;
        rst_n    = 1'b1;
        model_hi = 32'd0;
        model_lo = 32'd0;
    endtask

    task automatic test_mul_directed;
        int sc, oc;
        logic [1:0] os;
        run_op(OP_MULT, 32'hFFFFFFFE, 32'd3, sc, oc, os);
        checks_total++; if (sc !== 3) $display("[TB] FAIL mult_stall: got %0d expected 3", sc); else checks_passed++;
        checks_total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFA) $display("[TB] FAIL mult_hilo: got %h expected FFFFFFFFFFFFFFFA", {hi, lo}); else checks_passed++;
        checks_total++; if (oc !== 0) $display("[TB] FAIL mult_no_div_op: got %0d expected 0", oc); else checks_passed++;
        run_op(OP_MULTU, 32'hFFFFFFFE, 32'd3, sc, oc, os);
        checks_total++; if (sc !== 3) $display("[TB] FAIL multu_stall: got %0d expected 3", sc); else checks_passed++;
        checks_total++; if ({hi, lo} !== 64'h00000002_FFFFFFFA) $display("[TB] FAIL multu_hilo: got %h expected 00000002FFFFFFFA", {hi, lo}); else checks_passed++;
        model_hi = 32'h00000002;
        model_lo = 32'hFFFFFFFA;
    endtask

    task automatic test_div_directed;
        int sc, oc;
        logic [1:0] os;
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, sc, oc, os);
        checks_total++; if (oc !== 1 || os !== 2'b10) $display("[TB] FAIL div_op_pulse: got %0d cycles of %b expected 1 of 10", oc, os); else checks_passed++;
        checks_total++; if (sc !== 37) $display("[TB] FAIL div_stall: got %0d expected 37", sc); else checks_passed++;
        checks_total++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) $display("[TB] FAIL div_hilo: got lo=%h hi=%h expected lo=FFFFFFFD hi=FFFFFFFF", lo, hi); else checks_passed++;
        checks_total++; if (div_dividend !== 32'hFFFFFFF9 || div_divisor !== 32'd2) $display("[TB] FAIL div_operands: got %h/%h expected FFFFFFF9/00000002", div_dividend, div_divisor); else checks_passed++;
        run_op(OP_DIVU, 32'd100, 32'd7, sc, oc, os);
        checks_total++; if (oc !== 1 || os !== 2'b01) $display("[TB] FAIL divu_op_pulse: got %0d cycles of %b expected 1 of 01", oc, os); else checks_passed++;
        checks_total++; if (sc !== 35) $display("[TB] FAIL divu_stall: got %0d expected 35", sc); else checks_passed++;
        checks_total++; if (lo !== 32'd14 || hi !== 32'd2) $display("[TB] FAIL divu_hilo: got lo=%0d hi=%0d expected lo=14 hi=2", lo, hi); else checks_passed++;
        model_lo = 32'd14;
        model_hi = 32'd2;
    endtask

    task automatic test_back_to_back;
        int sc, oc;
        logic [1:0] os;
        run_op(OP_MTHI, 32'h12345678, 32'd0, sc, oc, os);
        checks_total++; if (sc !== 0) $display("[TB] FAIL mthi_stall: got %0d expected 0", sc); else checks_passed++;
        checks_total++; if (hi !== 32'h12345678 || lo !== model_lo) $display("[TB] FAIL mthi_value: got hi=%h lo=%h expected hi=12345678 lo=%h", hi, lo, model_lo); else checks_passed++;
        run_op(OP_MTLO, 32'h9ABCDEF0, 32'd0, sc, oc, os);
        checks_total++; if (sc !== 0) $display("[TB] FAIL mtlo_stall: got %0d expected 0", sc); else checks_passed++;
        checks_total++; if (lo !== 32'h9ABCDEF0 || hi !== 32'h12345678) $display("[TB] FAIL mtlo_value: got hi=%h lo=%h expected hi=12345678 lo=9ABCDEF0", hi, lo); else checks_passed++;
        run_op(OP_MULTU, 32'h00010000, 32'h00010001, sc, oc, os);
        checks_total++; if (sc !== 3) $display("[TB] FAIL b2b_mult_stall: got %0d expected 3", sc); else checks_passed++;
        checks_total++; if ({hi, lo} !== 64'h00000001_00010000) $display("[TB] FAIL b2b_mult_hilo: got %h expected 0000000100010000", {hi, lo}); else checks_passed++;
        model_hi = 32'h00000001;
        model_lo = 32'h00010000;
    endtask

    task automatic test_flush;
        int sc, oc;
        logic [1:0] os;
        // Flush in IDLE suppresses an MTHI
        @(negedge clk);
        ex_valid = 1'b1;
        ex_op    = OP_MTHI;
        ex_rs    = 32'hDEADBEEF;
        ex_flush = 1'b1;
        #1;
        checks_total++; if (stall !== 1'b0) $display("[TB] FAIL flush_idle_stall: got %b expected 0", stall); else checks_passed++;
        @(posedge clk);
        #1;
        checks_total++; if (hi !== model_hi) $display("[TB] FAIL flush_idle_hi: got %h expected %h", hi, model_hi); else checks_passed++;
        ex_valid = 1'b0;
        ex_flush = 1'b0;
        // DIV flushed in its sixth DIV_WAIT cycle, then DIVU 9/4 immediately
        @(negedge clk);
        ex_valid = 1'b1;
        ex_op    = OP_DIV;
        ex_rs    = 32'd1000;
        ex_rt    = 32'd3;
        repeat (7) @(negedge clk);
        ex_flush = 1'b1;
        #1;
        checks_total++; if (stall !== 1'b1) $display("[TB] FAIL flush_wait_stall: got %b expected 1", stall); else checks_passed++;
        @(negedge clk);
        ex_flush = 1'b0;
        ex_op    = OP_DIVU;
        ex_rs    = 32'd9;
        ex_rt    = 32'd4;
        #1;
        checks_total++; if (hi !== model_hi || lo !== model_lo) $display("[TB] FAIL flush_hilo_kept: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, model_hi, model_lo); else checks_passed++;
        checks_total++; if (stall !== 1'b1 || div_op !== 2'b00) $display("[TB] FAIL flush_waits_done: got stall=%b div_op=%b expected stall=1 div_op=00", stall, div_op); else checks_passed++;
        wait_release(sc, oc, os);
        checks_total++; if (sc !== 63) $display("[TB] FAIL flush_divu_stall: got %0d expected 63", sc); else checks_passed++;
        checks_total++; if (oc !== 1 || os !== 2'b01) $display("[TB] FAIL flush_divu_op: got %0d cycles of %b expected 1 of 01", oc, os); else checks_passed++;
        checks_total++; if (lo !== 32'd2 || hi !== 32'd1) $display("[TB] FAIL flush_divu_hilo: got lo=%0d hi=%0d expected lo=2 hi=1", lo, hi); else checks_passed++;
        model_lo = 32'd2;
        model_hi = 32'd1;
    endtask

    task automatic test_random;
        int sc, oc, es;
        logic [1:0] os;
        logic [2:0] op;
        logic [31:0] rs, rt;
        logic [63:0] r;
        for (int i = 0; i < 12; i++) begin
            op = 3'($urandom_range(1, 6));
            rs = $urandom;
            rt = $urandom;
            if ((op == OP_DIV || op == OP_DIVU) && $urandom_range(0, 5) == 0) rt = 32'd0;
            es = 0;
            case (op)
                OP_MULT:  begin r = ref_mul(1'b1, rs, rt); {model_hi, model_lo} = r; es = 3; end
                OP_MULTU: begin r = ref_mul(1'b0, rs, rt); {model_hi, model_lo} = r; es = 3; end
                OP_DIV, OP_DIVU: begin
                    if (rt == 32'd0) begin
                        es = 1;
                    end else begin
                        r = ref_div(op == OP_DIV, rs, rt);
                        model_lo = r[63:32];
                        model_hi = r[31:0];
                        es = (op == OP_DIV) ? 37 : 35;
                    end
                end
                OP_MTHI:  model_hi = rs;
                default:  model_lo = rs;
            endcase
            run_op(op, rs, rt, sc, oc, os);
            checks_total++; if (sc !== es) $display("[TB] FAIL rand%0d_stall op=%0d: got %0d expected %0d", i, op, sc, es); else checks_passed++;
            checks_total++; if (hi !== model_hi || lo !== model_lo) $display("[TB] FAIL rand%0d_hilo op=%0d rs=%h rt=%h: got %h_%h expected %h_%h", i, op, rs, rt, hi, lo, model_hi, model_lo); else checks_passed++;
        end
    endtask

    task automatic test_divzero_and_reset;
        int sc, oc;
        logic [1:0] os;
        run_op(OP_MTHI, 32'hA5A5A5A5, 32'd0, sc, oc, os);
        run_op(OP_MTLO, 32'h5A5A5A5A, 32'd0, sc, oc, os);
        run_op(OP_DIV, 32'd5, 32'd0, sc, oc, os);
        checks_total++; if (sc !== 1) $display("[TB] FAIL divzero_stall: got %0d expected 1", sc); else checks_passed++;
        checks_total++; if (oc !== 0) $display("[TB] FAIL divzero_div_op: got %0d active cycles expected 0", oc); else checks_passed++;
        checks_total++; if (hi !== 32'hA5A5A5A5 || lo !== 32'h5A5A5A5A) $display("[TB] FAIL divzero_hilo: got hi=%h lo=%h expected hi=A5A5A5A5 lo=5A5A5A5A", hi, lo); else checks_passed++;
        // Reset in the middle of a divide
        @(negedge clk);
        ex_valid = 1'b1;
        ex_op    = OP_DIV;
        ex_rs    = 32'd1000;
        ex_rt    = 32'd3;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks_total++; if (hi !== 32'd0 || lo !== 32'd0) $display("[TB] FAIL midreset_hilo: got hi=%h lo=%h expected 0", hi, lo); else checks_passed++;
        checks_total++; if (div_op !== 2'b00 || stall !== 1'b0) $display("[TB] FAIL midreset_ctrl: got div_op=%b stall=%b expected 00/0", div_op, stall); else checks_passed++;
        checks_total++; if (div_dividend !== 32'd0 || div_divisor !== 32'd0) $display("[TB] FAIL midreset_operands: got %h/%h expected 0/0", div_dividend, div_divisor); else checks_passed++;
        @(negedge clk);
        ex_valid = 1'b0;
        ex_op    = 3'b000;
        rst_n    = 1'b1;
        run_op(OP_MULT, 32'd7, 32'hFFFFFFFF, sc, oc, os);
        checks_total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF9 || sc !== 3) $display("[TB] FAIL post_reset_mult: got %h stall %0d expected FFFFFFFFFFFFFFF9 stall 3", {hi, lo}, sc); else checks_passed++;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        ex_valid = 1'b0;
        ex_op    = 3'b000;
        ex_rs    = 32'd0;
        ex_rt    = 32'd0;
        ex_flush = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        test_reset;
        test_mul_directed;
        test_div_directed;
        test_back_to_back;
        test_flush;
        test_random;
        test_divzero_and_reset;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Execute-stage multiply/divide controller owning the architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, runs multiplies on an internal 2-stage multiplier and sequences the 34-cycle iterative divider through its `div_op`/`done` handshake. It stalls the pipeline while busy and writes HI/LO on completion. It sits directly upstream of the divider and drives its operand and op inputs.

## Interface
- No parameters (fixed 32-bit datapath, 64-bit HI:LO).
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: EX holds a valid instruction.
- `ex_op` in 3: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as none).
- `ex_rs`, `ex_rt` in 32 each: source operands (rs = dividend / multiplicand).
- `ex_flush` in 1: cancel the in-flight operation.
- `stall` out 1: hold EX and earlier stages.
- `hi`, `lo` out 32 each: registered HI/LO, read directly by MFHI/MFLO.
- `div_op` out 2: to divider; 10 signed, 01 unsigned, 00 idle. Registered.
- `div_dividend`, `div_divisor` out 32 each: registered divider operands.
- `div_result` in 64: {quotient[63:32], remainder[31:0]}.
- `div_done` in 1: divider idle/result valid.

## Operation
- Reset (async, `rst_n`=0):
  - `hi`=`lo`=0, `div_op`=00, `div_dividend`=`div_divisor`=0, state IDLE.
  - `stall` forced 0.
- States: IDLE, MUL1, MUL2, DIV_ISSUE, DIV_WAIT, DONE.
- IDLE (requires `ex_valid`=1; `ex_flush`=1 suppresses all actions):
  - MTHI/MTLO: `hi`/`lo` <= `ex_rs` at the edge; no stall; stay IDLE.
  - MULT/MULTU: `stall`=1 combinationally. Capture operands, sign- (MULT) or zero-extended (MULTU) to 33 bits. Go MUL1.
  - DIV/DIVU with `ex_rt`=0: no divider launch, HI/LO unchanged; `stall`=1; go DONE.
  - DIV/DIVU with `div_done`=0 (divider still draining an aborted op): `stall`=1, stay IDLE.
  - DIV/DIVU with `div_done`=1: `stall`=1. Load `div_dividend`<=`ex_rs`, `div_divisor`<=`ex_rt`, `div_op`<=10 (DIV) or 01 (DIVU). Go DIV_ISSUE.
- MUL1: register the 66-bit product of the captured operands; go MUL2.
- MUL2: {`hi`,`lo`} <= product[63:0]; go DONE.
- DIV_ISSUE: `div_op` held for exactly this cycle (the divider samples it here while `div_done`=1). `div_op`<=00 at the edge; go DIV_WAIT.
- DIV_WAIT: on `div_done`=1, `lo`<=`div_result[63:32]`, `hi`<=`div_result[31:0]`; go DONE. Operands stay stable throughout.
- DONE: `stall`=0 for one cycle so the instruction leaves EX. `ex_valid`/`ex_op` are ignored here (no relaunch). Go IDLE.
- `stall`=1 in MUL1, MUL2, DIV_ISSUE, DIV_WAIT.
- `ex_flush` in MUL1/MUL2/DIV_ISSUE/DIV_WAIT: go IDLE next edge, HI/LO not written, `div_op`<=00.
  - A divider already launched runs to completion; its result is discarded.
  - The next DIV waits in IDLE for `div_done`.
- `ex_flush` in DONE: no effect (HI/LO already committed).
- Signed divide is sign-magnitude inside the divider; its result is taken verbatim.

## Timing
- MTHI/MTLO: 0 stall cycles; new value visible on `hi`/`lo` the next cycle.
- MULT/MULTU: `stall` high 3 cycles (IDLE, MUL1, MUL2); HI/LO valid in DONE.
- DIV: `div_done` falls the cycle after DIV_ISSUE and returns high 34 cycles later (DIVU: 32). `stall` high 37 cycles (DIVU: 35) from the accept cycle; HI/LO valid in DONE.
- Divide by zero: `stall` high 1 cycle.
- Back-to-back: a new op is accepted in the IDLE cycle after DONE.

## Test plan
- MULT rs=0xFFFFFFFE (-2), rt=3 -> `stall` 3 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=-7, rt=2 -> single-cycle `div_op`=10, `stall` 37 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=100, rt=7 -> `div_op`=01, `stall` 35 cycles; lo=14, hi=2.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 back-to-back -> no stall; hi/lo updated on successive cycles.
- DIV then `ex_flush` 5 cycles into DIV_WAIT, then an immediate DIVU 9/4 -> HI/LO untouched by the first op; `stall` holds in IDLE until `div_done`; then lo=2, hi=1.
- DIV rs=5, rt=0 -> `div_op` stays 00, `stall` 1 cycle, HI/LO unchanged. Assert `rst_n`=0 mid-DIV_WAIT -> hi=lo=0, `div_op`=00, `stall`=0 immediately.
